// File: rtl/ttl_memory_bus_capture_if.sv
// Request/response channel between the TTL capture front end and the
// AXI master stage. The capture block is the request master.
//
// Handshake: Req_Valid rises with Req_Write/Req_Addr/Req_WData and all four
// stay stable until the cycle in which Req_Valid and Req_Ready are both high;
// that cycle transfers exactly one request. Rsp_Valid is a one-cycle pulse
// qualifying Rsp_RData/Rsp_Error and needs no ready.
interface ttl_memory_bus_capture_if #(
    parameter int C_MST_AWIDTH = 32,
    parameter int C_DATA_WIDTH = 8
) ();
    logic                    Req_Valid;
    logic                    Req_Ready;
    logic                    Req_Write;
    logic [C_MST_AWIDTH-1:0] Req_Addr;
    logic [C_DATA_WIDTH-1:0] Req_WData;
    logic                    Rsp_Valid;
    logic [C_DATA_WIDTH-1:0] Rsp_RData;
    logic                    Rsp_Error;

    // Capture block side: issues requests, consumes completions
    modport master (
        output Req_Valid, Req_Write, Req_Addr, Req_WData,
        input  Req_Ready, Rsp_Valid, Rsp_RData, Rsp_Error
    );

    // Master stage side: accepts requests, returns completions
    modport slave (
        input  Req_Valid, Req_Write, Req_Addr, Req_WData,
        output Req_Ready, Rsp_Valid, Rsp_RData, Rsp_Error
    );
endinterface

// File: rtl/ttl_memory_bus_capture.sv
// TTL memory bus capture front end.
// Synchronises the asynchronous System86 TTL bus pins, waits for them to
// settle, captures one access per strobe and issues it as a single
// ready/valid request. Read data returns to the pad through Data_O/Data_T.
// Late strobe removal and completion errors raise sticky flags.
module ttl_memory_bus_capture #(
    parameter int C_ADDR_WIDTH    = 16,
    parameter int C_DATA_WIDTH    = 8,
    parameter int C_MST_AWIDTH    = 32,
    parameter int C_SETTLE_CYCLES = 2
) (
    input  logic                    Bus2IP_Clk,
    input  logic                    Bus2IP_Resetn,
    // TTL bus pins (asynchronous)
    input  logic                    ChipEnable_n,
    input  logic                    OutputEnable_n,
    input  logic                    WriteEnable_n,
    input  logic [C_ADDR_WIDTH-1:0] Address,
    input  logic [C_DATA_WIDTH-1:0] Data_I,
    output logic [C_DATA_WIDTH-1:0] Data_O,
    output logic                    Data_T,
    // Static window base in AXI space
    input  logic [C_MST_AWIDTH-1:0] MappedAddress,
    // Request/response channel to the master stage
    ttl_memory_bus_capture_if.master req_if,
    // Sticky error flags
    input  logic                    Err_Clear,
    output logic                    Late_Error,
    output logic                    Bus_Error,
    // Current FSM state, for observation only
    output logic [2:0]              dbg_state
);

    localparam int CNT_W = (C_SETTLE_CYCLES < 2) ? 1 : $clog2(C_SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_SETTLE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_HOLD     = 3'd4
    } state_e;

    state_e state_q, state_d;

    // Two-stage synchronisers; control vector is {CE_n, OE_n, WE_n}
    logic [2:0]              ctrl_s1_q, ctrl_s1_d, ctrl_s2_q, ctrl_s2_d;
    logic [C_ADDR_WIDTH-1:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;
    logic [C_DATA_WIDTH-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;

    // Captured access and settle counter
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [C_ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
    logic [C_DATA_WIDTH-1:0] data_lat_q, data_lat_d;
    logic                    rw_lat_q, rw_lat_d;
    // Strobe went away before this access finished
    logic                    late_q, late_d;

    // Registered outputs
    logic                    req_valid_q, req_valid_d;
    logic                    req_write_q, req_write_d;
    logic [C_MST_AWIDTH-1:0] req_addr_q, req_addr_d;
    logic [C_DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [C_DATA_WIDTH-1:0] data_o_q, data_o_d;
    logic                    data_t_q, data_t_d;
    logic                    late_err_q, late_err_d;
    logic                    bus_err_q, bus_err_d;

    // Synchronised pin view
    logic ce_s, oe_s, we_s;
    logic active_s;
    logic rw_s;
    logic changed_s;
    logic late_now;

    assign ce_s     = ctrl_s2_q[2];
    assign oe_s     = ctrl_s2_q[1];
    assign we_s     = ctrl_s2_q[0];
    // An access is live while selected with either strobe low; WE_n wins
    assign active_s = !ce_s && (!oe_s || !we_s);
    assign rw_s     = !we_s;
    assign changed_s = (addr_s2_q != addr_lat_q) || (data_s2_q != data_lat_q) ||
                       (rw_s != rw_lat_q);
    assign late_now = late_q || !active_s;

    // Synchroniser next values: shift pins through two stages
    always_comb begin
        ctrl_s1_d = {ChipEnable_n, OutputEnable_n, WriteEnable_n};
        ctrl_s2_d = ctrl_s1_q;
        addr_s1_d = Address;
        addr_s2_d = addr_s1_q;
        data_s1_d = Data_I;
        data_s2_d = data_s1_q;
    end

    // Synchroniser flops; reset to all ones so the bus looks idle
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            ctrl_s1_q <= '1;
            ctrl_s2_q <= '1;
            addr_s1_q <= '1;
            addr_s2_q <= '1;
            data_s1_q <= '1;
            data_s2_q <= '1;
        end else begin
            ctrl_s1_q <= ctrl_s1_d;
            ctrl_s2_q <= ctrl_s2_d;
            addr_s1_q <= addr_s1_d;
            addr_s2_q <= addr_s2_d;
            data_s1_q <= data_s1_d;
            data_s2_q <= data_s2_d;
        end
    end

    // FSM state register
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (active_s) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!active_s) begin
                    state_d = ST_IDLE;
                end else if (!changed_s && (cnt_q == CNT_MAX)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A request is never retracted, even after strobe removal
                if (req_valid_q && req_if.Req_Ready) begin
                    state_d = rw_lat_q ? ST_HOLD : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (req_if.Rsp_Valid) begin
                    state_d = late_now ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // One access per strobe: wait for the bus to go idle
                if (!active_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output and datapath logic
    always_comb begin
        cnt_d       = cnt_q;
        addr_lat_d  = addr_lat_q;
        data_lat_d  = data_lat_q;
        rw_lat_d    = rw_lat_q;
        late_d      = late_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        data_o_d    = data_o_q;
        // Clear first so a same-cycle set below takes priority
        late_err_d  = Err_Clear ? 1'b0 : late_err_q;
        bus_err_d   = Err_Clear ? 1'b0 : bus_err_q;

        case (state_q)
            ST_IDLE: begin
                late_d = 1'b0;
                if (active_s) begin
                    cnt_d      = CNT_ONE;
                    addr_lat_d = addr_s2_q;
                    data_lat_d = data_s2_q;
                    rw_lat_d   = rw_s;
                end
            end
            ST_SETTLE: begin
                if (active_s) begin
                    if (changed_s) begin
                        // Pins still moving: restart the stability count
                        cnt_d      = CNT_ONE;
                        addr_lat_d = addr_s2_q;
                        data_lat_d = data_s2_q;
                        rw_lat_d   = rw_s;
                    end else if (cnt_q == CNT_MAX) begin
                        req_valid_d = 1'b1;
                        req_write_d = rw_lat_q;
                        req_addr_d  = MappedAddress + C_MST_AWIDTH'(addr_lat_q);
                        req_wdata_d = data_lat_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!active_s) begin
                    late_d     = 1'b1;
                    late_err_d = 1'b1;
                end
                if (req_valid_q && req_if.Req_Ready) begin
                    req_valid_d = 1'b0;
                end
            end
            ST_WAIT_RSP: begin
                if (!active_s) begin
                    late_d     = 1'b1;
                    late_err_d = 1'b1;
                end
                if (req_if.Rsp_Valid) begin
                    if (req_if.Rsp_Error) begin
                        bus_err_d = 1'b1;
                    end
                    // Completion for an abandoned read is discarded
                    if (!late_now) begin
                        data_o_d = req_if.Rsp_Error ? '1 : req_if.Rsp_RData;
                    end
                end
            end
            default: ;
        endcase

        // Pad is driven only while holding a read with CE_n and OE_n low
        data_t_d = !((state_d == ST_HOLD) && !rw_lat_q && !ce_s && !oe_s);
    end

    // Datapath and output flops
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            cnt_d_unused_guard: begin end
            cnt_q       <= '0;
            addr_lat_q  <= '0;
            data_lat_q  <= '0;
            rw_lat_q    <= 1'b0;
            late_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            data_o_q    <= '0;
            data_t_q    <= 1'b1;
            late_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_lat_q  <= addr_lat_d;
            data_lat_q  <= data_lat_d;
            rw_lat_q    <= rw_lat_d;
            late_q      <= late_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            data_o_q    <= data_o_d;
            data_t_q    <= data_t_d;
            late_err_q  <= late_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign req_if.Req_Valid = req_valid_q;
    assign req_if.Req_Write = req_write_q;
    assign req_if.Req_Addr  = req_addr_q;
    assign req_if.Req_WData = req_wdata_q;
    assign Data_O           = data_o_q;
    assign Data_T           = data_t_q;
    assign Late_Error       = late_err_q;
    assign Bus_Error        = bus_err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ttl_memory_bus_capture.sv
// Bench for ttl_memory_bus_capture: directed cases plus randomized accesses
// checked against a transaction-level model of the TTL bus behaviour.
module tb_ttl_memory_bus_capture;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          ce_n, oe_n, we_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          data_t;
    logic [MW-1:0] base;
    logic          err_clear;
    logic          late_error, bus_error;
    logic [2:0]    dbg_state;

    ttl_memory_bus_capture_if #(.C_MST_AWIDTH(MW), .C_DATA_WIDTH(DW)) bus ();

    ttl_memory_bus_capture #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MST_AWIDTH(MW), .C_SETTLE_CYCLES(2)
    ) dut (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(rst_n),
        .ChipEnable_n(ce_n), .OutputEnable_n(oe_n), .WriteEnable_n(we_n),
        .Address(addr), .Data_I(data_i), .Data_O(data_o), .Data_T(data_t),
        .MappedAddress(base), .req_if(bus),
        .Err_Clear(err_clear), .Late_Error(late_error), .Bus_Error(bus_error),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [MW+DW:0] exp_q[$];     // {write, addr, wdata (0 for reads)}
    logic [DW-1:0]  model_data_o;
    logic           model_bus_err;
    logic           model_late_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_pins();
        ce_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
    endtask

    task automatic drive_pins(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr   = a;
        data_i = d;
        ce_n   = 1'b0;
        oe_n   = wr;
        we_n   = !wr;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        release_pins();
        bus.Req_Ready = 1'b0;
        bus.Rsp_Valid = 1'b0;
        bus.Rsp_RData = '0;
        bus.Rsp_Error = 1'b0;
        err_clear = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_data_o   = '0;
        model_bus_err  = 1'b0;
        model_late_err = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus.Req_Valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_flags();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        model_bus_err  = 1'b0;
        model_late_err = 1'b0;
        chk("clear_late", late_error, model_late_err);
        chk("clear_bus", bus_error, model_bus_err);
    endtask

    // Complete an access whose pins are already driven: expect a request
    // exp_lat edges later, accept it, answer reads, then end the strobe.
    task automatic serve(input int exp_lat, input int rdy_dly, input int rsp_dly,
                         input logic [DW-1:0] rdata, input logic err);
        logic [MW+DW:0] exp_req, got;
        int  n;
        bit  wr;
        wr = !we_n;
        exp_req = {wr, base + {16'h0000, addr}, wr ? data_i : 8'h00};
        exp_q.push_back(exp_req);
        wait_req(n);
        chk("req_latency", n, exp_lat);
        if (!bus.Req_Valid) begin
            void'(exp_q.pop_front());
            release_pins();
            repeat (6) tick();
            return;
        end
        got = {bus.Req_Write, bus.Req_Addr, bus.Req_Write ? bus.Req_WData : 8'h00};
        chk("req_fields", got, exp_q.pop_front());
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            chk("req_hold", {bus.Req_Valid, bus.Req_Write, bus.Req_Addr,
                             bus.Req_Write ? bus.Req_WData : 8'h00}, {1'b1, got});
        end
        bus.Req_Ready = 1'b1;
        tick();
        bus.Req_Ready = 1'b0;
        chk("req_drop", bus.Req_Valid, 1'b0);
        if (!wr) begin
            for (int i = 0; i < rsp_dly; i++) begin
                chk("pad_off_wait", data_t, 1'b1);
                tick();
            end
            bus.Rsp_Valid = 1'b1;
            bus.Rsp_RData = rdata;
            bus.Rsp_Error = err;
            tick();
            bus.Rsp_Valid = 1'b0;
            bus.Rsp_RData = DW'($urandom());
            bus.Rsp_Error = 1'b0;
            model_data_o  = err ? 8'hFF : rdata;
            model_bus_err = model_bus_err | err;
            chk("rd_data", data_o, model_data_o);
            chk("pad_on", data_t, 1'b0);
            chk("bus_err", bus_error, model_bus_err);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_pad", data_t, wr ? 1'b1 : 1'b0);
            chk("hold_no_req", bus.Req_Valid, 1'b0);
        end
        release_pins();
        tick();
        tick();
        chk("pad_still", data_t, wr ? 1'b1 : 1'b0);
        tick();
        chk("pad_release", data_t, 1'b1);
        chk("late_flag", late_error, model_late_err);
        repeat (2) tick();
    endtask

    // ---------------- stimulus ----------------
    int             n_seen;
    int             lat;
    bit             r_wr;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_data;
    logic [DW-1:0]  r_rdata;
    logic           r_err;
    int             r_rdy, r_rsp;

    initial begin
        addr   = '0;
        data_i = '0;
        base   = 32'h4000_0000;
        do_reset();

        // Reset state
        chk("rst_req_valid", bus.Req_Valid, 1'b0);
        chk("rst_req_addr", bus.Req_Addr, 32'h0);
        chk("rst_data_t", data_t, 1'b1);
        chk("rst_data_o", data_o, 8'h00);
        chk("rst_flags", {late_error, bus_error}, 2'b00);

        // Read 0x1234 at base 0x4000_0000, data 0xA5
        drive_pins(1'b0, 16'h1234, 8'h00);
        serve(5, 0, 2, 8'hA5, 1'b0);

        // Write 0x00FF data 0x3C with Req_Ready held low four cycles
        drive_pins(1'b1, 16'h00FF, 8'h3C);
        serve(5, 4, 0, 8'h00, 1'b0);

        // Address glitch right after assertion: only 0x0011 is requested
        drive_pins(1'b0, 16'h0010, 8'h11);
        tick();
        addr = 16'h0011;
        serve(5, 1, 1, 8'h42, 1'b0);

        // Two-cycle CE_n pulse: too short to be captured
        drive_pins(1'b0, 16'h0100, 8'h00);
        tick();
        tick();
        release_pins();
        n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.Req_Valid) n_seen++;
        end
        chk("short_pulse_no_req", n_seen, 0);

        // Address wrap and completion error
        base = 32'hFFFF_FFF0;
        drive_pins(1'b0, 16'h0020, 8'h00);
        serve(5, 0, 0, 8'h12, 1'b1);

        // Completion outside an access is ignored
        bus.Rsp_Valid = 1'b1;
        bus.Rsp_RData = 8'h5A;
        tick();
        bus.Rsp_Valid = 1'b0;
        tick();
        chk("stray_rsp_data", data_o, model_data_o);

        // CE_n removed during WAIT_RSP
        base = 32'h4000_0000;
        drive_pins(1'b0, 16'h0040, 8'h00);
        wait_req(lat);
        chk("late_rsp_latency", lat, 5);
        chk("late_rsp_req", {bus.Req_Valid, bus.Req_Write, bus.Req_Addr}, {2'b10, 32'h4000_0040});
        bus.Req_Ready = 1'b1;
        tick();
        bus.Req_Ready = 1'b0;
        release_pins();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("late_rsp_pad", data_t, 1'b1);
        end
        model_late_err = 1'b1;
        chk("late_rsp_flag", late_error, model_late_err);
        bus.Rsp_Valid = 1'b1;
        bus.Rsp_RData = 8'h77;
        tick();
        bus.Rsp_Valid = 1'b0;
        chk("late_rsp_discard", data_o, model_data_o);
        chk("late_rsp_pad_after", data_t, 1'b1);
        repeat (3) tick();
        chk("late_rsp_idle_req", bus.Req_Valid, 1'b0);

        clear_flags();

        // Strobe removed while the request is pending: no retraction
        drive_pins(1'b0, 16'h0050, 8'h00);
        wait_req(lat);
        chk("late_iss_latency", lat, 5);
        release_pins();
        repeat (3) tick();
        model_late_err = 1'b1;
        chk("late_iss_flag", late_error, model_late_err);
        chk("late_iss_no_retract", bus.Req_Valid, 1'b1);
        bus.Req_Ready = 1'b1;
        tick();
        bus.Req_Ready = 1'b0;
        chk("late_iss_drop", bus.Req_Valid, 1'b0);
        bus.Rsp_Valid = 1'b1;
        bus.Rsp_RData = 8'h99;
        tick();
        bus.Rsp_Valid = 1'b0;
        chk("late_iss_discard", data_o, model_data_o);
        chk("late_iss_pad", data_t, 1'b1);
        repeat (3) tick();

        // Reset while a request is pending
        drive_pins(1'b0, 16'h0060, 8'h00);
        wait_req(lat);
        chk("rst_iss_latency", lat, 5);
        rst_n = 1'b0;
        release_pins();
        tick();
        chk("rst_iss_req_valid", bus.Req_Valid, 1'b0);
        chk("rst_iss_pad", data_t, 1'b1);
        chk("rst_iss_flags", {late_error, bus_error}, 2'b00);
        chk("rst_iss_data_o", data_o, 8'h00);
        tick();
        rst_n = 1'b1;
        model_data_o   = '0;
        model_bus_err  = 1'b0;
        model_late_err = 1'b0;
        repeat (8) tick();
        chk("rst_iss_no_retry", bus.Req_Valid, 1'b0);

        // Randomized accesses
        for (int i = 0; i < 30; i++) begin
            r_wr    = 1'($urandom_range(0, 1));
            r_addr  = AW'($urandom());
            r_data  = DW'($urandom());
            r_rdata = DW'($urandom());
            r_err   = ($urandom_range(0, 6) == 0);
            r_rdy   = $urandom_range(0, 3);
            r_rsp   = $urandom_range(0, 3);
            base    = $urandom();
            if ($urandom_range(0, 5) == 0) clear_flags();
            drive_pins(r_wr, r_addr, r_data);
            serve(5, r_rdy, r_rsp, r_rdata, r_err);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
